// File: rtl/aes_mixcol_seq_if.sv
// Handshake bundle for the AES MixColumns sequencer: input state channel,
// output state channel and a busy flag.
interface aes_mixcol_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_bypass,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_bypass,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );
endinterface

// File: rtl/aes_mixcol_seq.sv
// AES MixColumns sequencer: one 128-bit state per handshake, mixed by
// COLS_PER_CYCLE shared column units over 4/COLS_PER_CYCLE cycles.
//
//   state | meaning
//   IDLE  | empty, ready for a new state
//   RUN   | mixing columns col_cnt..col_cnt+COLS_PER_CYCLE-1 each cycle
//   DONE  | result presented on out_data, waiting for out_ready
module aes_mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    aes_mixcol_seq_if.slave  bus
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t       state, state_next;
    logic [1:0]   col_cnt, col_cnt_next;
    logic [127:0] buffer, buffer_next;
    logic         in_ready_int;
    logic         last_step;

    logic [1:0]   col_idx [COLS_PER_CYCLE];
    logic [6:0]   col_lsb [COLS_PER_CYCLE];
    logic [31:0]  col_in  [COLS_PER_CYCLE];
    logic [31:0]  col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] m0, m1, m2, m3;
        b0 = c[31:24];
        b1 = c[23:16];
        b2 = c[15:8];
        b3 = c[7:0];
        m0 = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
        m1 = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
        m2 = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
        m3 = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
        return {m0, m1, m2, m3};
    endfunction

    // Column c lives at bits [127-32c -: 32], i.e. its LSB is (3-c)*32 = {~c, 5'b0}.
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign col_idx[g] = col_cnt + 2'(g);
        assign col_lsb[g] = {~col_idx[g], 5'b00000};
        assign col_in[g]  = buffer[col_lsb[g] +: 32];
        assign col_out[g] = mix_col(col_in[g]);
    end

    assign last_step = (col_idx[COLS_PER_CYCLE-1] == 2'd3);

    // out_ready reaches in_ready combinationally so a parked result can be
    // retired and the next state loaded on the same edge.
    assign in_ready_int = (state == ST_IDLE) | ((state == ST_DONE) & bus.out_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            col_cnt <= 2'd0;
            buffer  <= '0;
        end else begin
            state   <= state_next;
            col_cnt <= col_cnt_next;
            buffer  <= buffer_next;
        end
    end

    always_comb begin
        state_next   = state;
        col_cnt_next = col_cnt;
        buffer_next  = buffer;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    buffer_next  = bus.in_data;
                    col_cnt_next = 2'd0;
                    state_next   = bus.in_bypass ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                for (int u = 0; u < COLS_PER_CYCLE; u++) begin
                    buffer_next[col_lsb[u] +: 32] = col_out[u];
                end
                col_cnt_next = col_cnt + 2'(COLS_PER_CYCLE);
                if (last_step) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        buffer_next  = bus.in_data;
                        col_cnt_next = 2'd0;
                        state_next   = bus.in_bypass ? ST_DONE : ST_RUN;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = buffer;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Self-checking bench for aes_mixcol_seq: directed vectors on three widths
// plus a randomized stall/valid run against a GF(2^8) matrix model.
module tb_aes_mixcol_seq;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [63:0]  D4_HI    = 64'hd5d5d7d6_4d7ebdf8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aes_mixcol_seq_if m1();
    aes_mixcol_seq_if m2();
    aes_mixcol_seq_if m4();

    aes_mixcol_seq #(.COLS_PER_CYCLE(1)) dut1 (.clk(clk), .reset(reset), .bus(m1));
    aes_mixcol_seq #(.COLS_PER_CYCLE(2)) dut2 (.clk(clk), .reset(reset), .bus(m2));
    aes_mixcol_seq #(.COLS_PER_CYCLE(4)) dut4 (.clk(clk), .reset(reset), .bus(m4));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // GF(2^8) multiply by a small constant via shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 2; i++) begin
            if (((k >> i) & 1) == 1) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    // MixColumns as the circulant matrix [2 3 1 1] applied to each column.
    function automatic logic [127:0] mixcolumns_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   b [4];
        logic [7:0]   m;
        int           coef;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) b[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                m = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    case ((j - row + 4) % 4)
                        0:       coef = 2;
                        1:       coef = 3;
                        default: coef = 1;
                    endcase
                    m = m ^ gmul(b[j], coef);
                end
                r[127 - 32*c - 8*row -: 8] = m;
            end
        end
        return r;
    endfunction

    // Present a state at the next falling edge, hold until accepted; returns
    // at the falling edge after the accept edge with in_valid dropped.
    task automatic accept(input logic [127:0] d, input logic byp);
        int guard;
        @(negedge clk);
        m1.in_valid  = 1'b1;
        m1.in_data   = d;
        m1.in_bypass = byp;
        #1;
        guard = 0;
        while (!m1.in_ready && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!m1.in_ready) chk("accept_timeout", 128'(0), 128'(1));
        @(posedge clk);
        @(negedge clk);
        m1.in_valid = 1'b0;
    endtask

    // Count rising edges after the accept edge until out_valid shows.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m1.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!m1.out_valid) chk("out_valid_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sent;
        int rcvd;
        int cycles;
        logic pending;
        logic was_stalled;
        logic [127:0] held_data;
        logic [127:0] qexp [$];

        m1.in_valid = 1'b0; m1.in_data = '0; m1.in_bypass = 1'b0; m1.out_ready = 1'b1;
        m2.in_valid = 1'b0; m2.in_data = '0; m2.in_bypass = 1'b0; m2.out_ready = 1'b1;
        m4.in_valid = 1'b0; m4.in_data = '0; m4.in_bypass = 1'b0; m4.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_out_valid", 128'(m1.out_valid), 128'(0));
        chk("rst_busy",      128'(m1.busy),      128'(0));
        chk("rst_in_ready",  128'(m1.in_ready),  128'(1));
        chk("rst_out_data",  m1.out_data,        128'(0));
        @(negedge clk);
        reset = 1'b0;

        // FIPS-197 vector, one column per cycle
        accept(FIPS_IN, 1'b0);
        chk("c1_busy_run", 128'(m1.busy), 128'(1));
        wait_valid(lat);
        chk("c1_latency", 128'(lat), 128'(4));
        chk("c1_data",    m1.out_data, FIPS_OUT);
        @(negedge clk);
        chk("c1_valid_one_cycle", 128'(m1.out_valid), 128'(0));

        // Two columns per cycle
        @(negedge clk);
        m2.in_valid = 1'b1; m2.in_data = FIPS_IN; m2.in_bypass = 1'b0;
        #1;
        chk("c2_in_ready", 128'(m2.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        m2.in_valid = 1'b0;
        lat = 0;
        while (!m2.out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("c2_latency", 128'(lat), 128'(2));
        chk("c2_data",    m2.out_data, FIPS_OUT);

        // Four columns per cycle
        @(negedge clk);
        m4.in_valid = 1'b1; m4.in_data = FIPS_IN; m4.in_bypass = 1'b0;
        #1;
        chk("c4_in_ready", 128'(m4.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        m4.in_valid = 1'b0;
        lat = 0;
        while (!m4.out_valid && lat < 50) begin @(negedge clk); lat++; end
        chk("c4_latency", 128'(lat), 128'(1));
        chk("c4_data",    m4.out_data, FIPS_OUT);

        // Bypass, then a back-to-back bypass handoff
        accept(D4_IN, 1'b1);
        wait_valid(lat);
        chk("byp_latency", 128'(lat), 128'(0));
        chk("byp_data",    m1.out_data, D4_IN);
        m1.in_valid = 1'b1; m1.in_data = FIPS_IN; m1.in_bypass = 1'b1;
        #1;
        chk("byp_b2b_in_ready", 128'(m1.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        m1.in_valid = 1'b0;
        chk("byp_b2b_valid", 128'(m1.out_valid), 128'(1));
        chk("byp_b2b_data",  m1.out_data, FIPS_IN);
        @(negedge clk);
        chk("byp_b2b_drain", 128'(m1.out_valid), 128'(0));

        // Backpressure, then same-edge accept of the next block
        m1.out_ready = 1'b0;
        accept(FIPS_IN, 1'b0);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid",    128'(m1.out_valid), 128'(1));
            chk("bp_in_ready", 128'(m1.in_ready),  128'(0));
            chk("bp_busy",     128'(m1.busy),      128'(1));
            chk("bp_data",     m1.out_data,        FIPS_OUT);
        end
        m1.out_ready = 1'b1;
        m1.in_valid = 1'b1; m1.in_data = D4_IN; m1.in_bypass = 1'b0;
        #1;
        chk("bp_same_edge_ready", 128'(m1.in_ready), 128'(1));
        @(posedge clk);
        @(negedge clk);
        m1.in_valid = 1'b0;
        chk("bp_handoff_valid", 128'(m1.out_valid), 128'(0));
        chk("bp_handoff_data",  m1.out_data, D4_IN);
        wait_valid(lat);
        chk("bp_next_latency", 128'(lat), 128'(4));
        chk("bp_next_cols01",  128'(m1.out_data[127:64]), 128'(D4_HI));
        chk("bp_next_data",    m1.out_data, mixcolumns_ref(D4_IN));
        @(negedge clk);

        // Asynchronous reset after column 1 has been processed
        accept(FIPS_IN, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 128'(m1.busy), 128'(1));
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 128'(m1.out_valid), 128'(0));
        chk("abort_busy",      128'(m1.busy),      128'(0));
        chk("abort_in_ready",  128'(m1.in_ready),  128'(1));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_output", 128'(m1.out_valid), 128'(0));
        end
        held_data = {$urandom, $urandom, $urandom, $urandom};
        accept(held_data, 1'b0);
        wait_valid(lat);
        chk("abort_next_data", m1.out_data, mixcolumns_ref(held_data));
        @(negedge clk);

        // Random stall/valid stress against the model
        sent = 0; rcvd = 0; cycles = 0;
        pending = 1'b0; was_stalled = 1'b0; held_data = '0;
        while ((sent < 1000 || qexp.size() != 0) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (!pending && sent < 1000 && $urandom_range(3) != 0) begin
                pending      = 1'b1;
                m1.in_data   = {$urandom, $urandom, $urandom, $urandom};
                m1.in_bypass = ($urandom_range(3) == 0);
            end
            m1.in_valid  = pending;
            m1.out_ready = ($urandom_range(2) != 0);
            #1;
            if (was_stalled) begin
                chk("stress_hold_valid", 128'(m1.out_valid), 128'(1));
                chk("stress_hold_data",  m1.out_data, held_data);
            end
            if (m1.out_valid && m1.out_ready) begin
                chk("stress_expected_present", 128'(qexp.size() != 0), 128'(1));
                if (qexp.size() != 0) begin
                    chk("stress_data", m1.out_data, qexp.pop_front());
                    rcvd++;
                end
            end
            was_stalled = m1.out_valid && !m1.out_ready;
            held_data   = m1.out_data;
            if (m1.in_valid && m1.in_ready) begin
                qexp.push_back(m1.in_bypass ? m1.in_data : mixcolumns_ref(m1.in_data));
                sent++;
                pending = 1'b0;
            end
        end
        m1.in_valid = 1'b0;
        chk("stress_sent", 128'(sent), 128'(1000));
        chk("stress_rcvd", 128'(rcvd), 128'(1000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
